// File: rtl/ras_checkpointed_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ras_checkpointed_if                                    |
// | Description : Operation, checkpoint and status bundle for the        |
// |               checkpointed return address stack.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface ras_checkpointed_if #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int NUM_CKPT = 8
);
  localparam int c_TW = $clog2(NUM_CKPT);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic            i_op_valid;
  logic [1:0]      i_op;
  logic [XLEN-1:0] i_push_addr;
  logic            i_ckpt_valid;
  logic [c_TW-1:0] i_ckpt_tag;
  logic            i_restore_valid;
  logic [c_TW-1:0] i_restore_tag;
  logic [XLEN-1:0] o_top_addr;
  logic            o_top_valid;
  logic [c_CW-1:0] o_count;
  logic            o_overflow;

  modport master (
    output i_op_valid, i_op, i_push_addr, i_ckpt_valid, i_ckpt_tag,
           i_restore_valid, i_restore_tag,
    input  o_top_addr, o_top_valid, o_count, o_overflow
  );

  modport slave (
    input  i_op_valid, i_op, i_push_addr, i_ckpt_valid, i_ckpt_tag,
           i_restore_valid, i_restore_tag,
    output o_top_addr, o_top_valid, o_count, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/ras_checkpointed.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ras_checkpointed                                       |
// | Description : Circular return address stack with a per-branch-tag    |
// |               checkpoint file (sp, count, top entry) for repair on   |
// |               misprediction. Push, pop and pop-then-push supported.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ras_checkpointed #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int NUM_CKPT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  ras_checkpointed_if.slave     bus
);
  localparam int c_SPW = $clog2(DEPTH);
  localparam int c_CW  = c_SPW + 1;

  localparam logic [c_CW-1:0]  c_FULL     = c_CW'(DEPTH);
  localparam logic [c_CW-1:0]  c_CNT_ONE  = c_CW'(1);
  localparam logic [c_SPW-1:0] c_SP_ONE   = c_SPW'(1);
  localparam logic [1:0]       c_OP_PUSH  = 2'b00;
  localparam logic [1:0]       c_OP_POP   = 2'b01;
  localparam logic [1:0]       c_OP_SWAP  = 2'b10;

  // Live stack state
  logic [XLEN-1:0]  r_stack [DEPTH];
  logic [c_SPW-1:0] r_sp;
  logic [c_CW-1:0]  r_cnt;
  logic             r_ovf;

  // Checkpoint file, one slot per branch tag
  logic [c_SPW-1:0] r_ck_sp  [NUM_CKPT];
  logic [c_CW-1:0]  r_ck_cnt [NUM_CKPT];
  logic [XLEN-1:0]  r_ck_top [NUM_CKPT];

  logic [c_SPW-1:0] w_sp_m1;
  logic [XLEN-1:0]  w_top;
  logic             w_empty;
  logic             w_full;
  logic             w_live_op;
  logic             w_push;
  logic [c_SPW-1:0] w_rs_sp;
  logic [c_CW-1:0]  w_rs_cnt;
  logic [XLEN-1:0]  w_rs_top;

  logic [c_SPW-1:0] w_sp_nxt;
  logic [c_CW-1:0]  w_cnt_nxt;
  logic             w_ovf_nxt;
  logic             w_wr_en;
  logic [c_SPW-1:0] w_wr_idx;
  logic [XLEN-1:0]  w_wr_data;
  logic             w_ck_en;

  assign w_sp_m1  = r_sp - c_SP_ONE;
  assign w_top    = r_stack[w_sp_m1];
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == c_FULL);

  // A restore squashes any same-cycle op (wrong-path) and checkpoint.
  assign w_live_op = bus.i_op_valid & ~bus.i_restore_valid;
  // Pop-then-push on an empty stack degenerates to a plain push.
  assign w_push    = w_live_op & ((bus.i_op == c_OP_PUSH) |
                                  ((bus.i_op == c_OP_SWAP) & w_empty));

  assign w_rs_sp  = r_ck_sp[bus.i_restore_tag];
  assign w_rs_cnt = r_ck_cnt[bus.i_restore_tag];
  assign w_rs_top = r_ck_top[bus.i_restore_tag];

  // Next-state selection: restore, otherwise checkpoint plus optional op
  always_comb begin
    w_sp_nxt  = r_sp;
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    w_wr_en   = 1'b0;
    w_wr_idx  = r_sp;
    w_wr_data = bus.i_push_addr;
    w_ck_en   = 1'b0;
    if (bus.i_restore_valid) begin
      w_sp_nxt  = w_rs_sp;
      w_cnt_nxt = w_rs_cnt;
      w_ovf_nxt = 1'b0;
      w_wr_en   = (w_rs_cnt != '0);
      w_wr_idx  = w_rs_sp - c_SP_ONE;
      w_wr_data = w_rs_top;
    end else begin
      w_ck_en = bus.i_ckpt_valid;
      if (w_push) begin
        w_wr_en   = 1'b1;
        w_sp_nxt  = r_sp + c_SP_ONE;
        w_cnt_nxt = w_full ? r_cnt : r_cnt + c_CNT_ONE;
        w_ovf_nxt = r_ovf | w_full;
      end else if (w_live_op && bus.i_op == c_OP_POP && !w_empty) begin
        w_sp_nxt  = w_sp_m1;
        w_cnt_nxt = r_cnt - c_CNT_ONE;
      end else if (w_live_op && bus.i_op == c_OP_SWAP) begin
        // Non-empty swap: replace the top entry in place.
        w_wr_en  = 1'b1;
        w_wr_idx = w_sp_m1;
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_sp  <= w_sp_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  // Stack entry write; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_stack[w_wr_idx] <= w_wr_data;
    end
  end

  // Checkpoint capture of the pre-operation state of this cycle
  always_ff @(posedge clk) begin
    if (!reset && w_ck_en) begin
      r_ck_sp[bus.i_ckpt_tag]  <= r_sp;
      r_ck_cnt[bus.i_ckpt_tag] <= r_cnt;
      r_ck_top[bus.i_ckpt_tag] <= w_top;
    end
  end

  assign bus.o_top_addr  = w_empty ? '0 : w_top;
  assign bus.o_top_valid = ~w_empty;
  assign bus.o_count     = r_cnt;
  assign bus.o_overflow  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_ras_checkpointed.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ras_checkpointed                                    |
// | Description : Directed and randomized self-checking bench for the    |
// |               checkpointed return address stack (DEPTH=4 instance).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_ras_checkpointed;
  localparam int D = 4;
  localparam int NC = 8;
  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, SWAP = 2'b10, RSVD = 2'b11;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  ras_checkpointed_if #(.XLEN(32), .DEPTH(D), .NUM_CKPT(NC)) bus ();

  ras_checkpointed #(.XLEN(32), .DEPTH(D), .NUM_CKPT(NC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: circular array of return addresses, index arithmetic mod D
  logic [31:0] m_stack [D];
  int          m_sp, m_cnt;
  bit          m_ovf;
  int          ck_sp [NC];
  int          ck_cnt [NC];
  logic [31:0] ck_top [NC];
  bit          ck_written [NC];

  function automatic int wrap(int i);
    return (i % D + D) % D;
  endfunction

  function automatic logic [31:0] model_top();
    return (m_cnt > 0) ? m_stack[wrap(m_sp - 1)] : 32'h0;
  endfunction

  task automatic model_push(logic [31:0] a);
    m_stack[m_sp] = a;
    m_sp = wrap(m_sp + 1);
    if (m_cnt == D) m_ovf = 1'b1;
    else            m_cnt = m_cnt + 1;
  endtask

  task automatic model_step(bit rst, bit opv, logic [1:0] op, logic [31:0] a,
                            bit ckv, int ckt, bit rsv, int rt);
    if (rst) begin
      m_sp = 0; m_cnt = 0; m_ovf = 1'b0;
      foreach (ck_written[i]) ck_written[i] = 1'b0;
    end else if (rsv) begin
      if (!ck_written[rt]) begin
        n_fail++;
        $error("FAIL restore_unwritten: tag %0d observed unwritten expected written", rt);
      end
      m_sp  = ck_sp[rt];
      m_cnt = ck_cnt[rt];
      m_ovf = 1'b0;
      if (m_cnt > 0) m_stack[wrap(m_sp - 1)] = ck_top[rt];
    end else begin
      if (ckv) begin
        ck_sp[ckt]      = m_sp;
        ck_cnt[ckt]     = m_cnt;
        ck_top[ckt]     = m_stack[wrap(m_sp - 1)];
        ck_written[ckt] = 1'b1;
      end
      if (opv) begin
        case (op)
          PUSH: model_push(a);
          POP:  if (m_cnt > 0) begin m_sp = wrap(m_sp - 1); m_cnt = m_cnt - 1; end
          SWAP: if (m_cnt == 0) model_push(a); else m_stack[wrap(m_sp - 1)] = a;
          default: ;
        endcase
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "/top_addr"},  bus.o_top_addr, model_top());
    chk({tag, "/top_valid"}, 32'(bus.o_top_valid), 32'(m_cnt != 0));
    chk({tag, "/count"},     32'(bus.o_count), 32'(m_cnt));
    chk({tag, "/overflow"},  32'(bus.o_overflow), 32'(m_ovf));
  endtask

  // One clock cycle: drive, update model at the edge, sample #1 later
  task automatic step(string tag, bit rst, bit opv, logic [1:0] op, logic [31:0] a,
                      bit ckv, int ckt, bit rsv, int rt);
    reset               = rst;
    bus.i_op_valid      = opv;
    bus.i_op            = op;
    bus.i_push_addr     = a;
    bus.i_ckpt_valid    = ckv;
    bus.i_ckpt_tag      = 3'(ckt);
    bus.i_restore_valid = rsv;
    bus.i_restore_tag   = 3'(rt);
    @(posedge clk);
    model_step(rst, opv, op, a, ckv, ckt, rsv, rt);
    #1;
    reset               = 1'b0;
    bus.i_op_valid      = 1'b0;
    bus.i_ckpt_valid    = 1'b0;
    bus.i_restore_valid = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();        step("reset", 1, 0, PUSH, 0, 0, 0, 0, 0); endtask
  task automatic push(logic [31:0] a); step("push", 0, 1, PUSH, a, 0, 0, 0, 0); endtask
  task automatic pop();             step("pop",  0, 1, POP,  0, 0, 0, 0, 0); endtask
  task automatic swap(logic [31:0] a); step("swap", 0, 1, SWAP, a, 0, 0, 0, 0); endtask

  initial begin
    int cands[$];
    bit rst, opv, ckv, rsv;
    logic [1:0] op;
    int ckt, rt, r;

    reset = 1'b1;
    bus.i_op_valid = 1'b0; bus.i_op = PUSH; bus.i_push_addr = '0;
    bus.i_ckpt_valid = 1'b0; bus.i_ckpt_tag = '0;
    bus.i_restore_valid = 1'b0; bus.i_restore_tag = '0;
    m_sp = 0; m_cnt = 0; m_ovf = 1'b0;

    // Reset state
    do_reset(); do_reset();
    chk("reset_count", 32'(bus.o_count), 32'd0);
    chk("reset_valid", 32'(bus.o_top_valid), 32'd0);

    // Basic push/pop
    push(32'h100); push(32'h200); push(32'h300);
    chk("p3_top", bus.o_top_addr, 32'h300);
    chk("p3_count", 32'(bus.o_count), 32'd3);
    pop();
    chk("pop1_top", bus.o_top_addr, 32'h200);
    pop(); pop();
    chk("empty_valid", 32'(bus.o_top_valid), 32'd0);
    chk("empty_top", bus.o_top_addr, 32'h0);

    // Overflow and wrap at DEPTH=4
    do_reset();
    push(32'h10); push(32'h20); push(32'h30); push(32'h40); push(32'h50);
    chk("ovf_count", 32'(bus.o_count), 32'd4);
    chk("ovf_flag", 32'(bus.o_overflow), 32'd1);
    chk("ovf_top", bus.o_top_addr, 32'h50);
    pop(); chk("wrap_top1", bus.o_top_addr, 32'h40);
    pop(); chk("wrap_top2", bus.o_top_addr, 32'h30);
    pop(); chk("wrap_top3", bus.o_top_addr, 32'h20);
    pop(); chk("wrap_cnt0", 32'(bus.o_count), 32'd0);
    pop(); chk("underflow_cnt", 32'(bus.o_count), 32'd0);
    chk("ovf_sticky", 32'(bus.o_overflow), 32'd1);

    // Checkpoint with same-cycle push, wrong path, restore
    do_reset();
    push(32'hA0);
    step("ckpt_push", 0, 1, PUSH, 32'hB0, 1, 3, 0, 0);
    pop(); pop(); push(32'hC0);
    step("restore3", 0, 0, PUSH, 0, 0, 0, 1, 3);
    chk("rs3_top", bus.o_top_addr, 32'hA0);
    chk("rs3_count", 32'(bus.o_count), 32'd1);
    chk("rs3_ovf", 32'(bus.o_overflow), 32'd0);

    // Pop-then-push
    do_reset();
    push(32'h11); push(32'h22); swap(32'hEE);
    chk("swap_top", bus.o_top_addr, 32'hEE);
    chk("swap_count", 32'(bus.o_count), 32'd2);
    pop();
    chk("swap_pop", bus.o_top_addr, 32'h11);

    // Restore + push + checkpoint same cycle: only restore acts
    step("ckpt5", 0, 0, PUSH, 0, 1, 5, 0, 0);
    push(32'h33);
    step("rs_collide", 0, 1, PUSH, 32'h99, 1, 5, 1, 5);
    chk("collide_top", bus.o_top_addr, 32'h11);
    chk("collide_count", 32'(bus.o_count), 32'd1);
    push(32'h44); push(32'h55);
    step("rs5_again", 0, 0, PUSH, 0, 0, 0, 1, 5);
    chk("slot5_kept_top", bus.o_top_addr, 32'h11);
    chk("slot5_kept_cnt", 32'(bus.o_count), 32'd1);

    // Reset while a push is requested
    push(32'h1); push(32'h2); push(32'h3); push(32'h4);
    chk("pre_rst_ovf", 32'(bus.o_overflow), 32'd1);
    step("rst_push", 1, 1, PUSH, 32'h77, 0, 0, 0, 0);
    chk("rst_push_cnt", 32'(bus.o_count), 32'd0);
    chk("rst_push_valid", 32'(bus.o_top_valid), 32'd0);
    chk("rst_push_ovf", 32'(bus.o_overflow), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r   = $urandom_range(0, 99);
      rst = (r < 2);
      opv = ($urandom_range(0, 3) != 0);
      op  = 2'($urandom_range(0, 3));
      ckv = ($urandom_range(0, 2) == 0);
      ckt = $urandom_range(0, NC - 1);
      cands.delete();
      foreach (ck_written[k]) if (ck_written[k]) cands.push_back(k);
      rsv = (r >= 2) && (r < 14) && (cands.size() > 0);
      rt  = rsv ? cands[$urandom_range(0, cands.size() - 1)] : 0;
      step("rand", rst, opv, op, $urandom, ckv, ckt, rsv, rt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
